// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential AXI4-Lite instruction prefetcher feeding a DEPTH-entry FIFO, flushed by backend redirects.
// Optional macro IFU_FAULT_EN: store (rresp != OKAY) per entry, drive inst_fault, halt fetching after a fault.
module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              inst_fault
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_s;
    logic [ADDR_W-1:0]   araddr_r, araddr_s;
    logic                arvalid_r, arvalid_s;
    logic                rready_r, rready_s;
    logic                drop_r, drop_s;
    logic                halt_r, halt_s;
    logic                push_s, pop_s, fault_s;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]      count_r;
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
`ifdef IFU_FAULT_EN
    logic                fault_mem [DEPTH];
`else
    logic                unused_rresp_s;
    assign unused_rresp_s = ^rresp;
`endif

    // Fetch FSM next-state, AR/R channel controls, drop tracking and fetch PC update.
    always_comb begin
        state_s   = state_r;
        arvalid_s = arvalid_r;
        araddr_s  = araddr_r;
        rready_s  = rready_r;
        drop_s    = drop_r;
        push_s    = 1'b0;
`ifdef IFU_FAULT_EN
        fault_s   = (rresp != 2'b00);
`else
        fault_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!redirect_valid && !halt_r && (count_r < FULL_CNT)) begin
                    state_s   = ADDR;
                    arvalid_s = 1'b1;
                    araddr_s  = fetch_pc_r;
                end else begin
                    state_s   = IDLE;
                end
            end
            ADDR: begin
                // The AR stays up until accepted even across a redirect; its data is dropped instead.
                if (arready) begin
                    state_s   = DATA;
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                end else begin
                    state_s   = ADDR;
                end
                if (redirect_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            DATA: begin
                if (rvalid) begin
                    state_s  = IDLE;
                    rready_s = 1'b0;
                    if (drop_r || redirect_valid) begin
                        drop_s = 1'b0;
                    end else begin
                        push_s = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_s = 1'b1;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s   = IDLE;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                drop_s    = 1'b0;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_s = redirect_pc;
            halt_s     = 1'b0;
        end else if (push_s) begin
            fetch_pc_s = fetch_pc_r + STEP;
            halt_s     = fault_s;
        end else begin
            fetch_pc_s = fetch_pc_r;
            halt_s     = halt_r;
        end
    end

    // FSM and AXI control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            araddr_r   <= RESET_PC;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            drop_r     <= 1'b0;
            halt_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            araddr_r   <= araddr_s;
            arvalid_r  <= arvalid_s;
            rready_r   <= rready_s;
            drop_r     <= drop_s;
            halt_r     <= halt_s;
        end
    end

    assign pop_s = inst_valid && inst_ready;

    // FIFO pointers and occupancy; a redirect empties the queue and overrides any pop.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; the issued address travels with its instruction.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem[wr_ptr_r]  <= rdata;
            pc_mem[wr_ptr_r]    <= araddr_r;
`ifdef IFU_FAULT_EN
            fault_mem[wr_ptr_r] <= fault_s;
`endif
        end
    end

    assign arvalid    = arvalid_r;
    assign araddr     = araddr_r;
    assign rready     = rready_r;
    assign inst_valid = (count_r != {(PTR_W + 1){1'b0}});
    assign inst       = data_mem[rd_ptr_r];
    assign inst_pc    = pc_mem[rd_ptr_r];
`ifdef IFU_FAULT_EN
    assign inst_fault = inst_valid && fault_mem[rd_ptr_r];
`else
    assign inst_fault = 1'b0;
`endif
endmodule
